// File: rtl/vga_sync_monitor_pkg.sv
// Shared VGA 640x480 timing defaults, error bit positions and monitor FSM encodings.
package vga_sync_monitor_pkg;

  localparam int unsigned HTotalDef     = 800;
  localparam int unsigned HSyncDef      = 96;
  localparam int unsigned HActiveDef    = 640;
  localparam int unsigned VTotalDef     = 525;
  localparam int unsigned VSyncDef      = 2;
  localparam int unsigned VActiveDef    = 480;
  localparam int unsigned LockFramesDef = 2;

  localparam int unsigned ErrHPeriod = 0;
  localparam int unsigned ErrHWidth  = 1;
  localparam int unsigned ErrVPeriod = 2;
  localparam int unsigned ErrVWidth  = 3;
  localparam int unsigned ErrActive  = 4;

  localparam logic [1:0] StSearch  = 2'd0;
  localparam logic [1:0] StAcquire = 2'd1;
  localparam logic [1:0] StLocked  = 2'd2;

  function automatic logic [11:0] sat_inc12(input logic [11:0] v);
    return (v == 12'hfff) ? v : v + 12'd1;
  endfunction

endpackage

// File: rtl/vga_sync_monitor_edge.sv
// Registers one sync input, normalises it to active-high and flags its assert/deassert edges.
module vga_sync_monitor_edge #(
  parameter bit ActiveLow = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sync_i,
  output logic active_o,
  output logic assert_o,
  output logic deassert_o
);

  logic act_q;
  logic prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      act_q  <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      act_q  <= sync_i ^ ActiveLow;
      prev_q <= act_q;
    end
  end

  assign active_o   = act_q;
  assign assert_o   = act_q & ~prev_q;
  assign deassert_o = ~act_q & prev_q;

endmodule

// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing monitor: measures line/frame geometry, tracks lock, flags sticky
// deviations and recovers active-area pixel coordinates.
module vga_sync_monitor
  import vga_sync_monitor_pkg::*;
#(
  parameter int unsigned H_TOTAL         = HTotalDef,
  parameter int unsigned H_SYNC          = HSyncDef,
  parameter int unsigned H_ACTIVE        = HActiveDef,
  parameter int unsigned V_TOTAL         = VTotalDef,
  parameter int unsigned V_SYNC          = VSyncDef,
  parameter int unsigned V_ACTIVE        = VActiveDef,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1,
  parameter int unsigned LOCK_FRAMES     = LockFramesDef
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        vga_h_sync,
  input  logic        vga_v_sync,
  input  logic        in_display_area,
  input  logic        clear_err,
  output logic        locked,
  output logic        frame_done,
  output logic [11:0] line_len,
  output logic [10:0] frame_lines,
  output logic [4:0]  err,
  output logic        rx_valid,
  output logic [9:0]  rx_x,
  output logic [9:0]  rx_y
);

  localparam logic [11:0] HTotal   = 12'(H_TOTAL);
  localparam logic [11:0] HTimeout = 12'(2 * H_TOTAL);
  localparam logic [11:0] HSync    = 12'(H_SYNC);
  localparam logic [11:0] HActive  = 12'(H_ACTIVE);
  localparam logic [10:0] VTotal   = 11'(V_TOTAL);
  localparam logic [10:0] VSync    = 11'(V_SYNC);
  localparam logic [10:0] VActive  = 11'(V_ACTIVE);
  localparam logic [3:0]  LockCnt  = 4'(LOCK_FRAMES);

  logic hs_act, hs_asrt, hs_deasrt;
  logic vs_act, vs_asrt, vs_deasrt;

  vga_sync_monitor_edge #(.ActiveLow(SYNC_ACTIVE_LOW)) u_hs_edge (
    .clk_i      (clk),
    .rst_ni     (reset_n),
    .sync_i     (vga_h_sync),
    .active_o   (hs_act),
    .assert_o   (hs_asrt),
    .deassert_o (hs_deasrt)
  );

  vga_sync_monitor_edge #(.ActiveLow(SYNC_ACTIVE_LOW)) u_vs_edge (
    .clk_i      (clk),
    .rst_ni     (reset_n),
    .sync_i     (vga_v_sync),
    .active_o   (vs_act),
    .assert_o   (vs_asrt),
    .deassert_o (vs_deasrt)
  );

  logic        de_q;
  logic [11:0] h_cnt_q, h_cnt_d, hs_w_q, hs_w_d, de_cnt_q, de_cnt_d;
  logic [11:0] line_len_q, line_len_d;
  logic [10:0] v_lines_q, v_lines_d, vs_w_q, vs_w_d, act_lines_q, act_lines_d;
  logic [10:0] frame_lines_q, frame_lines_d;
  logic [9:0]  rx_y_q, rx_y_d;
  logic [4:0]  err_q, err_d, new_err;
  logic [3:0]  good_q, good_d;
  logic [1:0]  state_q, state_d;
  logic        h_seen_q, h_seen_d, frame_err_q, frame_err_d;
  logic        locked_q, locked_d, frame_done_q, frame_done_d;
  logic        tracking, chk_h, line_full, timeout;
  logic [10:0] v_lines_inc, act_inc;

  // Checks only run once the timing is followed: partial lines/frames after reset are ignored.
  assign tracking    = (state_q != StSearch);
  assign chk_h       = tracking && h_seen_q;
  assign line_full   = (de_cnt_q == HActive);
  assign v_lines_inc = v_lines_q + {10'd0, hs_asrt};
  assign act_inc     = act_lines_q + {10'd0, hs_asrt && line_full};
  assign timeout     = tracking && !hs_asrt && (h_cnt_q == HTimeout);

  always_comb begin
    new_err             = '0;
    new_err[ErrHPeriod] = (chk_h && hs_asrt && (h_cnt_q + 12'd1) != HTotal) || timeout;
    new_err[ErrHWidth]  = chk_h && hs_deasrt && (hs_w_q != HSync);
    new_err[ErrVPeriod] = tracking && vs_asrt && (v_lines_inc != VTotal);
    new_err[ErrVWidth]  = tracking && vs_deasrt && (vs_w_q != VSync);
    new_err[ErrActive]  = (chk_h && hs_asrt && de_cnt_q != '0 && !line_full) ||
                          (tracking && vs_asrt && act_inc != VActive);
  end

  always_comb begin
    h_cnt_d       = hs_asrt ? '0 : sat_inc12(h_cnt_q);
    hs_w_d        = hs_asrt ? 12'd1 : (hs_act ? hs_w_q + 12'd1 : hs_w_q);
    de_cnt_d      = hs_asrt ? '0 : de_cnt_q + {11'd0, de_q};
    h_seen_d      = h_seen_q | hs_asrt;
    line_len_d    = (hs_asrt && h_seen_q) ? h_cnt_q + 12'd1 : line_len_q;
    // A line closed on the same clock as the frame is counted into that frame.
    v_lines_d     = vs_asrt ? '0 : v_lines_inc;
    act_lines_d   = vs_asrt ? '0 : act_inc;
    vs_w_d        = vs_asrt ? {10'd0, hs_asrt} : (vs_act ? vs_w_q + {10'd0, hs_asrt} : vs_w_q);
    frame_lines_d = (vs_asrt && tracking) ? v_lines_inc : frame_lines_q;
    rx_y_d        = vs_asrt ? '0 : ((hs_asrt && de_cnt_q != '0) ? rx_y_q + 10'd1 : rx_y_q);
    err_d         = (clear_err ? '0 : err_q) | new_err;
    frame_err_d   = vs_asrt ? 1'b0 : (frame_err_q | (|new_err));
    frame_done_d  = vs_asrt && tracking;

    state_d = state_q;
    good_d  = good_q;
    case (state_q)
      StSearch: begin
        if (vs_asrt) begin
          state_d = StAcquire;
          good_d  = '0;
        end
      end
      StAcquire: begin
        if (vs_asrt) begin
          if (frame_err_q || (|new_err)) begin
            good_d = '0;
          end else begin
            good_d = good_q + 4'd1;
            if (good_q + 4'd1 == LockCnt) state_d = StLocked;
          end
        end
      end
      StLocked: begin
        if (|new_err) begin
          state_d = StAcquire;
          good_d  = '0;
        end
      end
      default: state_d = StSearch;
    endcase
    if (timeout) begin
      state_d = StSearch;
      good_d  = '0;
    end
    locked_d = (state_d == StLocked);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      de_q          <= 1'b0;
      h_cnt_q       <= '0;
      hs_w_q        <= '0;
      de_cnt_q      <= '0;
      h_seen_q      <= 1'b0;
      line_len_q    <= '0;
      v_lines_q     <= '0;
      act_lines_q   <= '0;
      vs_w_q        <= '0;
      frame_lines_q <= '0;
      rx_y_q        <= '0;
      err_q         <= '0;
      frame_err_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      state_q       <= StSearch;
      good_q        <= '0;
      locked_q      <= 1'b0;
    end else begin
      de_q          <= in_display_area;
      h_cnt_q       <= h_cnt_d;
      hs_w_q        <= hs_w_d;
      de_cnt_q      <= de_cnt_d;
      h_seen_q      <= h_seen_d;
      line_len_q    <= line_len_d;
      v_lines_q     <= v_lines_d;
      act_lines_q   <= act_lines_d;
      vs_w_q        <= vs_w_d;
      frame_lines_q <= frame_lines_d;
      rx_y_q        <= rx_y_d;
      err_q         <= err_d;
      frame_err_q   <= frame_err_d;
      frame_done_q  <= frame_done_d;
      state_q       <= state_d;
      good_q        <= good_d;
      locked_q      <= locked_d;
    end
  end

  assign locked      = locked_q;
  assign frame_done  = frame_done_q;
  assign line_len    = line_len_q;
  assign frame_lines = frame_lines_q;
  assign err         = err_q;
  assign rx_valid    = de_q;
  assign rx_x        = de_cnt_q[9:0];
  assign rx_y        = rx_y_q;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor using a shrunken 20x10 timing so many frames fit quickly.
module tb_vga_sync_monitor;

  localparam int HT   = 20;
  localparam int HS   = 3;
  localparam int HA   = 12;
  localparam int VT   = 10;
  localparam int VS   = 2;
  localparam int VA   = 6;
  localparam int HDE0 = 5;
  localparam int VDE0 = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        h_sync = 1'b1;
  logic        v_sync = 1'b1;
  logic        de = 1'b0;
  logic        clear_err = 1'b0;
  logic        locked, frame_done, rx_valid;
  logic [11:0] line_len;
  logic [10:0] frame_lines;
  logic [4:0]  err;
  logic [9:0]  rx_x, rx_y;

  int n_vec = 0;
  int n_bad = 0;
  int fd_cnt = 0;
  int rxy_max = 0;
  int line_xmax [VT];

  vga_sync_monitor #(
    .H_TOTAL(HT), .H_SYNC(HS), .H_ACTIVE(HA), .V_TOTAL(VT), .V_SYNC(VS), .V_ACTIVE(VA),
    .SYNC_ACTIVE_LOW(1'b1), .LOCK_FRAMES(2)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .vga_h_sync      (h_sync),
    .vga_v_sync      (v_sync),
    .in_display_area (de),
    .clear_err       (clear_err),
    .locked          (locked),
    .frame_done      (frame_done),
    .line_len        (line_len),
    .frame_lines     (frame_lines),
    .err             (err),
    .rx_valid        (rx_valid),
    .rx_x            (rx_x),
    .rx_y            (rx_y)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (frame_done) fd_cnt++;
  endtask

  task automatic drive_line(input int y, input int hsw, input int dlen, input bit hs_en,
                            input int clr_x);
    int xmax;
    xmax = -1;
    for (int x = 0; x < HT; x++) begin
      h_sync    = ~(hs_en && x < hsw);
      v_sync    = ~(y < VS);
      de        = (y >= VDE0) && (y < VDE0 + VA) && (x >= HDE0) && (x < HDE0 + dlen);
      clear_err = (x == clr_x);
      tick();
      if (rx_valid) begin
        if (int'(rx_x) > xmax) xmax = int'(rx_x);
        if (int'(rx_y) > rxy_max) rxy_max = int'(rx_y);
      end
    end
    line_xmax[y] = xmax;
  endtask

  // fl: faulty line with fhsw/fdlen; lines nohs_lo..nohs_hi carry no hsync; clear on clr_line.
  task automatic drive_frame(input int y0, input int y1, input int fl, input int fhsw,
                             input int fdlen, input int nohs_lo, input int nohs_hi,
                             input int clr_line, input int clr_x);
    for (int y = y0; y < y1; y++) begin
      drive_line(y, (y == fl) ? fhsw : HS, (y == fl) ? fdlen : HA,
                 !(y >= nohs_lo && y <= nohs_hi), (y == clr_line) ? clr_x : -1);
    end
  endtask

  task automatic clean_frame();
    drive_frame(0, VT, -1, HS, HA, -1, -2, -1, -1);
  endtask

  initial begin
    // Reset held for 100 ns
    repeat (10) tick();
    check("rst_locked", locked, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_line_len", line_len, 0);
    check("rst_frame_lines", frame_lines, 0);
    check("rst_err", err, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_xy", {rx_x, rx_y}, 0);
    reset_n = 1'b1;

    // Lock from reset: ACQUIRE at first vsync, LOCKED at third
    fd_cnt = 0;
    clean_frame();
    clean_frame();
    check("t1_not_yet_locked", locked, 0);
    clean_frame();
    check("t1_locked", locked, 1);
    check("t1_line_len", line_len, HT);
    check("t1_frame_lines", frame_lines, VT);
    check("t1_err", err, 0);
    check("t1_frame_done_cnt", fd_cnt, 2);
    check("t1_rx_x_max", line_xmax[4], HA - 1);
    check("t1_rx_y_max", rxy_max, VA - 1);

    // Short hsync on one line while locked
    drive_frame(0, VT, 4, HS - 1, HA, -1, -2, -1, -1);
    check("t2_err_hwidth", err, 5'b00010);
    check("t2_unlocked", locked, 0);
    clean_frame();
    clean_frame();
    check("t2_still_acquiring", locked, 0);
    clean_frame();
    check("t2_relocked", locked, 1);
    check("t2_err_sticky", err, 5'b00010);

    // Missing hsync for three lines -> timeout to SEARCH
    drive_frame(0, VT, -1, HS, HA, 3, 5, -1, -1);
    check("t3_err_timeout", err, 5'b00011);
    check("t3_unlocked", locked, 0);
    fd_cnt = 0;
    clean_frame();
    check("t3_search_no_frame_done", fd_cnt, 0);
    clean_frame();
    clean_frame();
    check("t3_relocked", locked, 1);
    check("t3_line_len", line_len, HT);

    // clear_err on the very clock a new width error is detected
    drive_frame(0, VT, 4, HS - 1, HA, -1, -2, 4, 3);
    check("t6_err_wins_clear", err, 5'b00010);
    check("t6_unlocked", locked, 0);
    drive_frame(0, VT, -1, HS, HA, -1, -2, 4, 10);
    check("t6_clear_alone", err, 0);

    // One active line one pixel short
    rxy_max = 0;
    drive_frame(0, VT, VDE0 + 2, HS, HA - 1, -1, -2, -1, -1);
    check("t4_err_active", err, 5'b10000);
    check("t4_rx_x_short_line", line_xmax[VDE0 + 2], HA - 2);
    check("t4_rx_x_full_line", line_xmax[VDE0 + 1], HA - 1);
    check("t4_rx_y_max", rxy_max, VA - 1);

    // Reset mid-frame
    drive_frame(0, 3, -1, HS, HA, -1, -2, -1, -1);
    check("t5_pre_line_len", line_len, HT);
    reset_n = 1'b0;
    #2;
    check("t5_rst_line_len", line_len, 0);
    check("t5_rst_frame_lines", frame_lines, 0);
    check("t5_rst_err", err, 0);
    check("t5_rst_locked", locked, 0);
    tick();
    reset_n = 1'b1;
    fd_cnt = 0;
    drive_frame(3, VT, -1, HS, HA, -1, -2, -1, -1);
    clean_frame();
    check("t5_no_pulse_first_vsync", fd_cnt, 0);
    clean_frame();
    check("t5_pulse_second_vsync", fd_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
